// File: rtl/wb_stage.sv
// Writeback stage: 32x32 integer register file with write-first bypass to decode,
// 64-bit cycle/instret counters behind a CSR read port, and a registered retire trace.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            reg_write_en,
  input  logic [XLEN-1:0] wb_mux_out,
  input  logic [31:0]     inst_Wb,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     csr_addr,
  output logic [31:0]     csr_rdata,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            retire_we
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [63:0]     cycle_reg;
  logic [63:0]     instret_reg;
  logic [4:0]      rd;
  logic            we;
  logic [1:0][4:0] port_addr;

  assign rd        = inst_Wb[11:7];
  assign we        = wb_valid & reg_write_en & (rd != 5'd0);
  assign port_addr = {rs2_addr, rs1_addr};

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[rd] <= wb_mux_out;
    end
  end

  // Two independent read ports; a same-cycle write to the addressed register wins.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [XLEN-1:0] data;
      always_comb begin
        data = '0;
        if (port_addr[gi] != 5'd0) begin
          if (we && (port_addr[gi] == rd)) begin
            data = wb_mux_out;
          end else begin
            data = regs_reg[port_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rs1_data = g_port[0].data;
  assign rs2_data = g_port[1].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;
      if (wb_valid) begin
        instret_reg <= instret_reg + 64'd1;
      end
    end
  end

  // Counter reads see the registered (pre-increment) value.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'hC00: csr_rdata = cycle_reg[31:0];
      12'hC80: csr_rdata = cycle_reg[63:32];
      12'hC02: csr_rdata = instret_reg[31:0];
      12'hC82: csr_rdata = instret_reg[63:32];
      default: csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      retire_we    <= 1'b0;
    end else begin
      retire_valid <= wb_valid;
      retire_rd    <= rd;
      retire_we    <= we;
      retire_data  <= we ? wb_mux_out : '0;
    end
  end

endmodule
